// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle EX-stage ALU: op codes, FSM states and
// the multi-cycle op classifier used by both the datapath and its bench.
package alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_AND   = 4'b0001;
  localparam logic [3:0] OP_SLL   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_MUL   = 4'b0101;
  localparam logic [3:0] OP_SRA   = 4'b0110;
  localparam logic [3:0] OP_SRL   = 4'b0111;
  localparam logic [3:0] OP_OR    = 4'b1000;
  localparam logic [3:0] OP_SLT   = 4'b1001;
  localparam logic [3:0] OP_SLTU  = 4'b1010;
  localparam logic [3:0] OP_UNDEF = 4'b1011;
  localparam logic [3:0] OP_DIV   = 4'b1100;
  localparam logic [3:0] OP_DIVU  = 4'b1101;
  localparam logic [3:0] OP_REM   = 4'b1110;
  localparam logic [3:0] OP_REMU  = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Divide codes only take the iterative path when the divider is built.
  function automatic logic is_multicycle(input logic [3:0] op);
`ifdef ALU_MC_DIV_EN
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_DIVU) ||
           (op == OP_REM) || (op == OP_REMU);
`else
    return (op == OP_MUL);
`endif
  endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative engine: one WIDTH-cycle counter shared by a shift-add multiplier and,
// when ALU_MC_DIV_EN is defined, a restoring divider. done pulses with the final step.
module alu_iter_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             abort,
  input  logic             start,
`ifdef ALU_MC_DIV_EN
  input  logic [3:0]       op,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);

  logic             busy_q;
  logic [CW-1:0]    cnt_q;
  logic             last;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_nxt;

  assign last = busy_q && (cnt_q == CW'(WIDTH - 1));
  assign done = last;

  // The engine goes idle on its last step, so the counter never re-enters a run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (abort) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
    end else if (busy_q) begin
      busy_q <= !last;
      cnt_q  <= last ? '0 : cnt_q + 1'b1;
    end
  end

  assign acc_nxt = mplier_q[0] ? acc_q + mcand_q : acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (start) begin
      acc_q    <= '0;
      mcand_q  <= a;
      mplier_q <= b;
    end else if (busy_q) begin
      acc_q    <= acc_nxt;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
    end
  end

`ifdef ALU_MC_DIV_EN
  logic             sgn;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvsr_q;
  logic             is_div_q;
  logic             is_rem_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic             dz_q;
  logic [WIDTH:0]   r_sh;
  logic             ge;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic [WIDTH-1:0] quo_res;
  logic [WIDTH-1:0] rem_res;

  // Signed ops divide magnitudes and fix signs at the end; the remainder follows the dividend.
  assign sgn   = (op == OP_DIV) || (op == OP_REM);
  assign a_mag = (sgn && a[WIDTH-1]) ? -a : a;
  assign b_mag = (sgn && b[WIDTH-1]) ? -b : b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      is_div_q  <= 1'b0;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
    end else if (start) begin
      rem_q     <= '0;
      quo_q     <= a_mag;
      dvsr_q    <= b_mag;
      is_div_q  <= (op != OP_MUL);
      is_rem_q  <= (op == OP_REM) || (op == OP_REMU);
      neg_quo_q <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_rem_q <= sgn && a[WIDTH-1];
      dz_q      <= (b == '0);
    end else if (busy_q) begin
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
    end
  end

  // A kept partial remainder is always below the divisor, so WIDTH bits suffice.
  always_comb begin
    r_sh    = {rem_q, quo_q[WIDTH-1]};
    ge      = (r_sh >= {1'b0, dvsr_q});
    rem_nxt = ge ? r_sh[WIDTH-1:0] - dvsr_q : r_sh[WIDTH-1:0];
    quo_nxt = {quo_q[WIDTH-2:0], ge};
    quo_res = dz_q ? '1 : (neg_quo_q ? -quo_nxt : quo_nxt);
    rem_res = neg_rem_q ? -rem_nxt : rem_nxt;
  end

  assign result = is_div_q ? (is_rem_q ? rem_res : quo_res) : acc_nxt;
`else
  assign result = acc_nxt;
`endif

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle EX-stage ALU with valid/ready handshakes on both sides and a
// registered zero flag. Defining ALU_MC_DIV_EN adds the iterative divide/remainder ops.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [WIDTH-1:0]  data1_i,
  input  logic [WIDTH-1:0]  data2_i,
  input  logic [CTRL_W-1:0] ALUCtrl_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [WIDTH-1:0]  data_o,
  output logic              Zero_o
);

  localparam int SHW = $clog2(WIDTH);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic             zero_q;
  logic             load;
  logic             accept;
  logic             multi;
  logic             md_start;
  logic             md_done;
  logic [WIDTH-1:0] md_result;
  logic [WIDTH-1:0] alu_res;
  logic [SHW-1:0]   shamt;

  assign ready_o  = (state_q == IDLE) || ((state_q == DONE) && ready_i);
  assign accept   = valid_i && ready_o && !flush_i;
  assign multi    = is_multicycle(ALUCtrl_i);
  assign md_start = accept && multi;

  assign shamt = data2_i[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (ALUCtrl_i)
      OP_ADD:  alu_res = data1_i + data2_i;
      OP_AND:  alu_res = data1_i & data2_i;
      OP_SLL:  alu_res = data1_i << shamt;
      OP_XOR:  alu_res = data1_i ^ data2_i;
      OP_SUB:  alu_res = data1_i - data2_i;
      OP_SRA:  alu_res = WIDTH'($signed(data1_i) >>> shamt);
      OP_SRL:  alu_res = data1_i >> shamt;
      OP_OR:   alu_res = data1_i | data2_i;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(data1_i) < $signed(data2_i)};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, data1_i < data2_i};
      OP_MUL, OP_UNDEF, OP_DIV, OP_DIVU, OP_REM, OP_REMU: alu_res = '0;
      default: alu_res = '0;
    endcase
  end

  // A consumed result and a fresh acceptance can share a cycle, so DONE re-dispatches like IDLE.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    data_d  = alu_res;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            state_d = multi ? BUSY : DONE;
            load    = !multi;
          end else if ((state_q == DONE) && ready_i) begin
            state_d = IDLE;
          end
        end
        BUSY: begin
          if (md_done) begin
            state_d = DONE;
            load    = 1'b1;
            data_d  = md_result;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      data_q  <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        data_q <= data_d;
        zero_q <= (data_d == '0);
      end
    end
  end

  assign valid_o = (state_q == DONE);
  assign data_o  = data_q;
  assign Zero_o  = zero_q;

  alu_iter_muldiv #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk   (clk_i),
    .rst_n (rst_i),
    .abort (flush_i),
    .start (md_start),
`ifdef ALU_MC_DIV_EN
    .op    (ALUCtrl_i),
`endif
    .a     (data1_i),
    .b     (data2_i),
    .done  (md_done),
    .result(md_result)
  );

endmodule
